// File: rtl/ddr4_dqsw_training_ctrl.sv
//-----------------------------------------------------------------------------
// ddr4_dqsw_training_ctrl
//
// Fabric-side write-leveling (DQSW) controller for one DDR4 lane. While
// training, it toggles DQS through the IOD. It reloads the delay line and then
// steps it one tap at a time. At each tap it takes a majority vote of the DQ
// feedback, and it stops at the first 0->1 transition of the voted feedback.
//
// Ports
//   FAB_CLK                    fabric clock, all logic on the rising edge
//   RESET                      synchronous, active-high reset
//   START                      one-cycle request to begin (ignored while BUSY)
//   RX_DATA_0[1:0]             IOD receive data; bit 0 is DQ level feedback
//   EYE_MONITOR_EARLY_0/LATE_0 IOD eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE_0  IOD delay-line saturation; aborts training
//   TX_DATA_0/OE_DATA_0        DQS pattern / output enable (active when BUSY)
//   DELAY_LINE_LOAD_0          one-cycle pulse, reload default delay
//   DELAY_LINE_MOVE_0          one-cycle pulse, step delay by one tap
//   DELAY_LINE_DIRECTION_0     step direction, 1 = increment
//   EYE_MONITOR_CLEAR_FLAGS_0  one-cycle pulse, clear the eye-monitor flags
//   BUSY                       training in progress
//   TRAIN_DONE / TRAIN_ERR     sticky success / failure
//   TAP_RESULT                 tap count captured at DONE or ERROR
//   EYE_STATUS[1:0]            {late, early} seen in the last sample window
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ddr4_dqsw_training_ctrl #(
  parameter int TAP_WIDTH     = 7,
  parameter int MAX_TAPS      = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [1:0]           RX_DATA_0,
  input  logic                 EYE_MONITOR_EARLY_0,
  input  logic                 EYE_MONITOR_LATE_0,
  input  logic                 DELAY_LINE_OUT_OF_RANGE_0,
  output logic [1:0]           TX_DATA_0,
  output logic [1:0]           OE_DATA_0,
  output logic                 DELAY_LINE_LOAD_0,
  output logic                 DELAY_LINE_MOVE_0,
  output logic                 DELAY_LINE_DIRECTION_0,
  output logic                 EYE_MONITOR_CLEAR_FLAGS_0,
  output logic                 BUSY,
  output logic                 TRAIN_DONE,
  output logic                 TRAIN_ERR,
  output logic [TAP_WIDTH-1:0] TAP_RESULT,
  output logic [1:0]           EYE_STATUS
);

  // One phase counter serves both the settle wait and the sample window.
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int ONES_W  = $clog2(SAMPLES + 1);

  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ONES_W-1:0]    VOTE_THRESH = ONES_W'(SAMPLES / 2);
  localparam logic [TAP_WIDTH-1:0] LAST_TAP    = TAP_WIDTH'(MAX_TAPS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [TAP_WIDTH-1:0]  tap_cnt;
  logic [CNT_W-1:0]      phase_cnt;
  logic [ONES_W-1:0]     ones_cnt;
  logic [1:0]            eye_acc;
  logic                  prev_fb;
  logic                  prev_fb_valid;

  logic                  fb;
  logic                  found_edge;
  logic                  oor;

  // Only bit 0 of the receive bus carries write-level feedback.
  logic                  unused_rx_msb;
  assign unused_rx_msb = RX_DATA_0[1];

  // A tie in the vote counts as 0.
  assign fb         = (ones_cnt > VOTE_THRESH);
  // A success needs a 0 seen first, so an initial 1 never wins.
  assign found_edge = prev_fb_valid & ~prev_fb & fb;
  assign oor        = DELAY_LINE_OUT_OF_RANGE_0;

  //---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb infers a latch.
    next_state                = state;
    BUSY                      = 1'b0;
    DELAY_LINE_LOAD_0         = 1'b0;
    DELAY_LINE_MOVE_0         = 1'b0;
    EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) next_state = S_LOAD;
      end
      S_LOAD: begin
        BUSY              = 1'b1;
        DELAY_LINE_LOAD_0 = 1'b1;
        next_state        = S_CLEAR;
      end
      S_CLEAR: begin
        BUSY                      = 1'b1;
        EYE_MONITOR_CLEAR_FLAGS_0 = 1'b1;
        next_state                = S_SETTLE;
      end
      S_SETTLE: begin
        BUSY = 1'b1;
        if (oor)                           next_state = S_ERROR;
        else if (phase_cnt == SETTLE_LAST) next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        BUSY = 1'b1;
        if (oor)                           next_state = S_ERROR;
        else if (phase_cnt == SAMPLE_LAST) next_state = S_EVAL;
      end
      S_EVAL: begin
        BUSY = 1'b1;
        // Saturation outranks the feedback decision.
        if (oor)                      next_state = S_ERROR;
        else if (found_edge)          next_state = S_DONE;
        else if (tap_cnt == LAST_TAP) next_state = S_ERROR;
        else                          next_state = S_STEP;
      end
      S_STEP: begin
        BUSY              = 1'b1;
        DELAY_LINE_MOVE_0 = 1'b1;
        next_state        = S_CLEAR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The delay line only ever steps upward, and DQS toggles once per clock
  // for the whole run.
  assign DELAY_LINE_DIRECTION_0 = BUSY;
  assign TX_DATA_0              = BUSY ? 2'b01 : 2'b00;
  assign OE_DATA_0              = BUSY ? 2'b11 : 2'b00;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  //---------------------------------------------------------------------------
  // Datapath: counters, vote, sticky results
  //---------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      tap_cnt       <= '0;
      phase_cnt     <= '0;
      ones_cnt      <= '0;
      eye_acc       <= '0;
      prev_fb       <= 1'b0;
      prev_fb_valid <= 1'b0;
      TRAIN_DONE    <= 1'b0;
      TRAIN_ERR     <= 1'b0;
      TAP_RESULT    <= '0;
      EYE_STATUS    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (START) begin
            TRAIN_DONE <= 1'b0;
            TRAIN_ERR  <= 1'b0;
          end
        end
        S_LOAD: begin
          tap_cnt       <= '0;
          prev_fb       <= 1'b0;
          prev_fb_valid <= 1'b0;
        end
        S_CLEAR: begin
          // Start each tap with a fresh settle count, vote and eye window.
          phase_cnt <= '0;
          ones_cnt  <= '0;
          eye_acc   <= '0;
        end
        S_SETTLE: begin
          phase_cnt <= (phase_cnt == SETTLE_LAST) ? '0 : phase_cnt + CNT_W'(1);
        end
        S_SAMPLE: begin
          phase_cnt <= phase_cnt + CNT_W'(1);
          ones_cnt  <= ones_cnt + ONES_W'(RX_DATA_0[0]);
          eye_acc   <= eye_acc | {EYE_MONITOR_LATE_0, EYE_MONITOR_EARLY_0};
        end
        S_EVAL: begin
          EYE_STATUS    <= eye_acc;
          prev_fb       <= fb;
          prev_fb_valid <= 1'b1;
        end
        S_STEP: begin
          tap_cnt <= tap_cnt + TAP_WIDTH'(1);
        end
        default: ;
      endcase

      if (next_state == S_DONE && state != S_DONE) begin
        TRAIN_DONE <= 1'b1;
        TAP_RESULT <= tap_cnt;
      end
      if (next_state == S_ERROR && state != S_ERROR) begin
        TRAIN_ERR  <= 1'b1;
        TAP_RESULT <= tap_cnt;
      end
    end
  end

endmodule

// File: doc/ddr4_dqsw_training_ctrl.md
Name: ddr4_dqsw_training_ctrl

Overview:
Fabric-side controller for one DDR4 write-leveling (DQSW) training lane. It drives the lane IOD's DQS toggle pattern, dynamic delay-line controls and eye-monitor flag clear. It samples the DQ feedback returned through the IOD receive path and steps the delay tap-by-tap until it finds the 0->1 feedback transition. It then reports the winning tap count, or an error.

Parameters:
TAP_WIDTH, 7, width of the tap counter and TAP_RESULT
MAX_TAPS, 127, last tap evaluated before declaring failure
SETTLE_CYCLES, 8, cycles waited after each clear or step before sampling
SAMPLES, 4, feedback samples per tap; majority vote

Ports:
FAB_CLK  input  1  fabric clock; all logic rising-edge
RESET  input  1  synchronous, active-high reset
START  input  1  single-cycle request to begin training
RX_DATA_0  input  2  IOD receive data; bit 0 is DQ write-level feedback
EYE_MONITOR_EARLY_0  input  1  IOD eye-monitor early flag
EYE_MONITOR_LATE_0  input  1  IOD eye-monitor late flag
DELAY_LINE_OUT_OF_RANGE_0  input  1  IOD delay-line saturation
TX_DATA_0  output  2  DQS pattern to IOD
OE_DATA_0  output  2  DQS output enable to IOD
DELAY_LINE_LOAD_0  output  1  one-cycle pulse; reload delay-line default
DELAY_LINE_MOVE_0  output  1  one-cycle pulse; step delay one tap
DELAY_LINE_DIRECTION_0  output  1  step direction; 1 = increment
EYE_MONITOR_CLEAR_FLAGS_0  output  1  one-cycle pulse; clear eye flags
BUSY  output  1  training in progress
TRAIN_DONE  output  1  sticky success
TRAIN_ERR  output  1  sticky failure
TAP_RESULT  output  TAP_WIDTH  tap count at DONE or ERROR
EYE_STATUS  output  2  {late, early} flags seen in the final sample window

Behaviour:
- Reset state: state IDLE; all outputs 0; counters and prev_fb_valid cleared.
- Reset mid-operation: the FSM returns to IDLE on the next edge. No MOVE or LOAD pulse is issued after reset asserts. TAP_RESULT clears.
- States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, DONE, ERROR.
- IDLE: wait for START, then go to LOAD.
- DONE/ERROR: hold the sticky flag. START restarts training at LOAD and clears both flags.
- START while BUSY: ignored.
- LOAD: DELAY_LINE_LOAD_0=1 for 1 cycle; tap_cnt<=0; prev_fb_valid<=0; go to CLEAR.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS_0=1 for 1 cycle; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles; go to SAMPLE.
- SAMPLE: for SAMPLES cycles, ones_cnt += RX_DATA_0[0]. EARLY and LATE are OR-accumulated into eye_acc, which clears on entry.
- EVAL: fb = (ones_cnt > SAMPLES/2), so a tie counts as 0. EYE_STATUS<=eye_acc. Then, in priority order:
  - prev_fb_valid & !prev_fb & fb: go to DONE.
  - tap_cnt==MAX_TAPS: go to ERROR.
  - otherwise: go to STEP.
  - In all cases prev_fb<=fb and prev_fb_valid<=1.
- STEP: DELAY_LINE_MOVE_0=1 for 1 cycle with DIRECTION=1; tap_cnt<=tap_cnt+1; go to CLEAR.
- Success rule: an initial fb=1 is not a success; a 0 must be seen first.
- Out of range: DELAY_LINE_OUT_OF_RANGE_0 sampled high in SETTLE, SAMPLE or EVAL goes to ERROR immediately. This has priority over EVAL decisions.
- On entry to DONE or ERROR: TAP_RESULT<=tap_cnt.
- DELAY_LINE_DIRECTION_0: 1 from LOAD until DONE/ERROR, 0 otherwise.
- TX_DATA_0 / OE_DATA_0: 2'b01 / 2'b11 whenever BUSY, giving one DQS pulse per FAB_CLK; 2'b00 / 2'b00 otherwise.
- BUSY: 1 in states LOAD through STEP.
- Per-tap latency: 1 (CLEAR) + SETTLE_CYCLES + SAMPLES + 1 (EVAL) + 1 (STEP) = 15 cycles at defaults.
- Tap-0 latency: START to first EVAL = 1 + 1 + 1 + 8 + 4 = 15 cycles.
- tap_cnt never wraps; MAX_TAPS bounds it.

Test Plan:
- Feedback 0 for taps 0-9, 1 from tap 10 -> exactly 10 MOVE pulses, 1 LOAD pulse, TRAIN_DONE=1, TAP_RESULT=10, BUSY=0.
- Feedback stuck at 1 -> 127 MOVE pulses, TRAIN_ERR=1, TAP_RESULT=127, TRAIN_DONE=0.
- Majority vote: tap 4 fb=0; tap 5 samples 1,1,0,0 -> continues (tie = 0); tap 6 samples 1,1,1,0 -> DONE, TAP_RESULT=6.
- OUT_OF_RANGE pulsed during SETTLE of tap 3 -> TRAIN_ERR=1, TAP_RESULT=3, no further MOVE pulses.
- RESET during SAMPLE of tap 2 -> all outputs 0 next cycle; no activity until START.
- START mid-training -> ignored, result unchanged. START in DONE -> flags cleared, fresh LOAD pulse, new run. LATE high during the final window -> EYE_STATUS=2'b10.
